// File: rtl/avalon_st_pkt_sink_if.sv
// -----------------------------------------------------------------------------
// avalon_st_pkt_sink_if
//
// Avalon-ST link bundle (readyLatency 0) between a packet source and a sink.
//
// Signals:
//   data           DATA_W   beat payload
//   valid          1        beat valid (source -> sink)
//   ready          1        sink can accept (sink -> source)
//   startofpacket  1        first beat of a packet
//   endofpacket    1        last beat of a packet
//   empty          EMPTY_W  unused symbols in the end-of-packet beat
//
// Modports:
//   master  the source side (drives data/valid/framing, samples ready)
//   slave   the sink side   (samples data/valid/framing, drives ready)
// -----------------------------------------------------------------------------
interface avalon_st_pkt_sink_if #(
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 5
);

  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               ready;
  logic               startofpacket;
  logic               endofpacket;
  logic [EMPTY_W-1:0] empty;

  modport master (
    output data,
    output valid,
    output startofpacket,
    output endofpacket,
    output empty,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  startofpacket,
    input  endofpacket,
    input  empty,
    output ready
  );

endinterface

// File: rtl/avalon_st_pkt_sink.sv
// -----------------------------------------------------------------------------
// avalon_st_pkt_sink
//
// Receiving end of the 256-bit Avalon-ST packet link. Accepted beats are
// stored in a first-word-fall-through FIFO that downstream logic drains with a
// simple pop strobe. A two-state framing checker watches the accepted stream,
// drops stray beats that arrive outside a packet, flags packets that are
// reopened before they end, and reports completed-packet count and the byte
// length of the most recently completed packet.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   st          Avalon-ST sink (slave modport); ready is a register
//   out_valid   FIFO head valid
//   out_data    FIFO head data        (0 while out_valid=0)
//   out_sop     FIFO head SOP flag    (0 while out_valid=0)
//   out_eop     FIFO head EOP flag    (0 while out_valid=0)
//   out_empty   FIFO head empty field (0 unless out_eop=1)
//   out_pop     consume the head; ignored while out_valid=0
//   pkt_count   completed packets, wraps at 2^32
//   last_len    byte length of the last completed packet, saturating
//   err_no_sop  one-cycle pulse: beat accepted outside a packet without SOP
//   err_no_eop  one-cycle pulse: SOP accepted while a packet is still open
// -----------------------------------------------------------------------------
module avalon_st_pkt_sink #(
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 5,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,

  avalon_st_pkt_sink_if.slave st,

  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  input  logic               out_pop,

  output logic [31:0]        pkt_count,
  output logic [LEN_W-1:0]   last_len,
  output logic               err_no_sop,
  output logic               err_no_eop
);

  // ---------------------------------------------------------------------------
  // Local constants and types
  // ---------------------------------------------------------------------------
  localparam int BEAT_BYTES = DATA_W / 8;
  // Wide enough to hold BEAT_BYTES itself (a full beat), not just BEAT_BYTES-1.
  localparam int BYTES_W    = $clog2(BEAT_BYTES) + 1;
  localparam int PTR_W      = $clog2(DEPTH);
  // Occupancy needs one more bit than the pointers to represent "full".
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(BEAT_BYTES);
  localparam logic [LEN_W-1:0]   LEN_MAX    = '1;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               ready_q;

  state_t             state;
  logic [LEN_W-1:0]   acc;

  logic               fire;       // handshake completed this cycle
  logic               stray;      // beat arrives in IDLE without SOP
  logic               push;       // accepted beat is written to the FIFO
  logic               pop;        // head is consumed this cycle

  logic [BYTES_W-1:0] beat_bytes;
  logic [LEN_W:0]     acc_wide;
  logic [LEN_W-1:0]   acc_sum;
  logic [LEN_W-1:0]   pkt_len;    // acc value after this beat

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  assign st.ready = ready_q;
  assign fire     = st.valid & ready_q;
  assign stray    = (state == IDLE) & ~st.startofpacket;
  // Stray beats complete the handshake (the source must not stall on them)
  // but never reach the FIFO.
  assign push     = fire & ~stray;
  assign pop      = out_pop & (count != '0);

  // Only EOP beats carry a meaningful empty field; store 0 otherwise so the
  // head never shows a stale value.
  assign wr_entry = '{
    data:  st.data,
    sop:   st.startofpacket,
    eop:   st.endofpacket,
    empty: st.endofpacket ? st.empty : '0
  };

  // ---------------------------------------------------------------------------
  // Byte accounting for the beat on the bus
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    beat_bytes = FULL_BYTES;
    if (st.endofpacket) begin
      beat_bytes = FULL_BYTES - BYTES_W'(st.empty);
    end

    // One spare bit catches the carry out so the running length saturates
    // instead of wrapping on very long packets.
    acc_wide = {1'b0, acc} + (LEN_W + 1)'(beat_bytes);
    acc_sum  = acc_wide[LEN_W] ? LEN_MAX : acc_wide[LEN_W-1:0];

    // An SOP beat restarts the count from its own bytes, even when it
    // abandons an open packet.
    pkt_len  = st.startofpacket ? LEN_W'(beat_bytes) : acc_sum;
  end

  // ---------------------------------------------------------------------------
  // FIFO occupancy, pointers and registered ready
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its inputs regardless of
  // the order in which always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count   <= count_next;
      // Looks at next occupancy, so a pop that frees a slot re-opens ready
      // one cycle later; a push that fills the last slot closes it in time.
      ready_q <= (count_next < DEPTH_C);
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // through the occupancy count, which is reset, so clearing it would cost a
  // wide reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through read side
  // ---------------------------------------------------------------------------
  // Outputs are forced to zero while the FIFO is empty so stale or
  // never-written entries are not visible.
  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head.data  : '0;
  assign out_sop   = out_valid ? head.sop   : 1'b0;
  assign out_eop   = out_valid ? head.eop   : 1'b0;
  assign out_empty = out_valid ? head.empty : '0;

  // ---------------------------------------------------------------------------
  // Framing FSM, byte accumulator and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      pkt_count  <= '0;
      last_len   <= '0;
      err_no_sop <= 1'b0;
      err_no_eop <= 1'b0;
    end else begin
      // Error flags are pulses: cleared every cycle unless re-raised below.
      err_no_sop <= fire & stray;
      err_no_eop <= fire & (state == IN_PKT) & st.startofpacket;

      if (push) begin
        acc <= pkt_len;
        if (st.endofpacket) begin
          state     <= IDLE;
          last_len  <= pkt_len;
          pkt_count <= pkt_count + 32'd1;
        end else begin
          state     <= IN_PKT;
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_st_pkt_sink.sv
// -----------------------------------------------------------------------------
// tb_avalon_st_pkt_sink
//
// Self-checking bench for avalon_st_pkt_sink. A small framing/length model
// runs alongside the stimulus; every accepted beat that should be stored is
// pushed to a scoreboard queue, and a monitor pops and compares it whenever
// the DUT head is consumed.
// -----------------------------------------------------------------------------
module tb_avalon_st_pkt_sink;

  localparam int DATA_W  = 256;
  localparam int EMPTY_W = 5;
  localparam int DEPTH   = 16;
  localparam int LEN_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  avalon_st_pkt_sink_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) st ();

  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_sop;
  logic               out_eop;
  logic [EMPTY_W-1:0] out_empty;
  logic               out_pop = 1'b0;
  logic [31:0]        pkt_count;
  logic [LEN_W-1:0]   last_len;
  logic               err_no_sop;
  logic               err_no_eop;

  avalon_st_pkt_sink #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W),
    .DEPTH   (DEPTH),
    .LEN_W   (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_empty  (out_empty),
    .out_pop    (out_pop),
    .pkt_count  (pkt_count),
    .last_len   (last_len),
    .err_no_sop (err_no_sop),
    .err_no_eop (err_no_eop)
  );

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } exp_t;

  exp_t sb_q[$];

  // Reference framing model state.
  bit          m_in_pkt;
  int          m_acc;
  int unsigned m_cnt;
  int          m_last;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Head is compared at the negedge before the edge that consumes it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_pop) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pop", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_data",  out_data,  e.data);
        check("out_sop",   out_sop,   e.sop);
        check("out_eop",   out_eop,   e.eop);
        check("out_empty", out_empty, e.empty);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) begin
      r[i*32 +: 32] = $urandom();
    end
    return r;
  endfunction

  // Called just after an edge that accepted the beat still held on the bus.
  task automatic model_accept();
    int   bytes;
    bit   store;
    bit   e_sop;
    bit   e_eop;
    exp_t e;
    bytes = st.endofpacket ? 32 - int'(st.empty) : 32;
    store = 1'b1;
    e_sop = 1'b0;
    e_eop = 1'b0;
    if (st.startofpacket) begin
      if (m_in_pkt) e_eop = 1'b1;
      m_acc = bytes;
      if (st.endofpacket) begin
        m_cnt++;
        m_last   = m_acc;
        m_in_pkt = 1'b0;
      end else begin
        m_in_pkt = 1'b1;
      end
    end else if (!m_in_pkt) begin
      e_sop = 1'b1;
      store = 1'b0;
    end else begin
      m_acc = m_acc + bytes;
      if (m_acc > 65535) m_acc = 65535;
      if (st.endofpacket) begin
        m_cnt++;
        m_last   = m_acc;
        m_in_pkt = 1'b0;
      end
    end
    if (store) begin
      e.data  = st.data;
      e.sop   = st.startofpacket;
      e.eop   = st.endofpacket;
      e.empty = st.endofpacket ? st.empty : '0;
      sb_q.push_back(e);
    end
    check("err_no_sop", err_no_sop, e_sop);
    check("err_no_eop", err_no_eop, e_eop);
    check("pkt_count",  pkt_count,  m_cnt);
    check("last_len",   last_len,   m_last);
  endtask

  // One clock: decide acceptance at the negedge (ready is stable until the
  // next edge), then advance to just after the edge.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = st.ready && st.valid && !rst;
    @(posedge clk);
    #1;
    if (acc) model_accept();
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  task automatic send(input bit s, input bit e, input logic [EMPTY_W-1:0] emp);
    bit acc;
    int n;
    st.data          = rand_data();
    st.startofpacket = s;
    st.endofpacket   = e;
    st.empty         = emp;
    st.valid         = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    st.valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic do_reset();
    out_pop  = 1'b0;
    st.valid = 1'b0;
    rst      = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_ready",      st.ready,   0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_data",   out_data,   0);
    check("rst_out_sop",    out_sop,    0);
    check("rst_out_eop",    out_eop,    0);
    check("rst_out_empty",  out_empty,  0);
    check("rst_pkt_count",  pkt_count,  0);
    check("rst_last_len",   last_len,   0);
    check("rst_err_no_sop", err_no_sop, 0);
    check("rst_err_no_eop", err_no_eop, 0);
    sb_q.delete();
    m_in_pkt = 1'b0;
    m_acc    = 0;
    m_cnt    = 0;
    m_last   = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", st.ready, 1);
  endtask

  task automatic stall_beat(input int i);
    st.data          = rand_data();
    st.startofpacket = (i == 0);
    st.endofpacket   = (i == 19);
    st.empty         = '0;
    st.valid         = (i < 20);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit acc;
    int idx;
    int n;

    st.data          = '0;
    st.valid         = 1'b0;
    st.startofpacket = 1'b0;
    st.endofpacket   = 1'b0;
    st.empty         = '0;

    // Single-beat packet, 4 unused symbols.
    do_reset();
    out_pop = 1'b1;
    send(1'b1, 1'b1, 5'd4);
    check("t1_out_valid",   out_valid, 1);
    check("t1_out_empty",   out_empty, 4);
    idle(1);
    check("t1_drained",     out_valid, 0);
    check("t1_pkt_count",   pkt_count, 1);
    check("t1_last_len",    last_len,  28);

    // Three-beat packet; non-EOP beats carry junk in empty.
    do_reset();
    out_pop = 1'b1;
    send(1'b1, 1'b0, 5'd3);
    send(1'b0, 1'b0, 5'd9);
    send(1'b0, 1'b1, 5'd0);
    idle(2);
    check("t2_pkt_count",   pkt_count,  1);
    check("t2_last_len",    last_len,   96);
    check("t2_err_no_sop",  err_no_sop, 0);
    check("t2_err_no_eop",  err_no_eop, 0);

    // Backpressure: 20-beat packet against a stalled reader.
    do_reset();
    idx = 0;
    stall_beat(idx);
    repeat (30) begin
      tick(acc);
      if (acc) begin
        idx++;
        stall_beat(idx);
      end
    end
    check("t3_accepts_full", idx,       16);
    check("t3_ready_full",   st.ready,  0);
    check("t3_out_valid",    out_valid, 1);
    out_pop = 1'b1;
    tick(acc);
    out_pop = 1'b0;
    if (acc) begin
      idx++;
      stall_beat(idx);
    end
    check("t3_ready_reopen", st.ready, 1);
    repeat (10) begin
      tick(acc);
      if (acc) begin
        idx++;
        stall_beat(idx);
      end
    end
    check("t3_accepts_stall", idx,      17);
    check("t3_ready_refull",  st.ready, 0);
    out_pop = 1'b1;
    n = 0;
    while (idx < 20 && n < 200) begin
      tick(acc);
      if (acc) begin
        idx++;
        stall_beat(idx);
      end
      n++;
    end
    st.valid = 1'b0;
    idle(20);
    check("t3_accepts_total", idx,        20);
    check("t3_fifo_empty",    out_valid,  0);
    check("t3_sb_drained",    sb_q.size(), 0);
    check("t3_pkt_count",     pkt_count,  1);
    check("t3_last_len",      last_len,   640);

    // Stray beat in IDLE: discarded, one-cycle error pulse.
    do_reset();
    out_pop = 1'b1;
    send(1'b0, 1'b0, 5'd0);
    check("t4_not_stored",  out_valid,  0);
    idle(1);
    check("t4_pulse_end",   err_no_sop, 0);
    check("t4_pkt_count",   pkt_count,  0);

    // SOP while a packet is open: old packet abandoned.
    do_reset();
    out_pop = 1'b1;
    send(1'b1, 1'b0, 5'd0);
    send(1'b0, 1'b0, 5'd0);
    send(1'b1, 1'b0, 5'd0);
    send(1'b0, 1'b1, 5'd0);
    check("t5_pkt_count",   pkt_count,  1);
    check("t5_last_len",    last_len,   64);
    idle(1);
    check("t5_pulse_end",   err_no_eop, 0);

    // Reset in the middle of a packet with data still in the FIFO.
    do_reset();
    send(1'b1, 1'b0, 5'd0);
    send(1'b0, 1'b0, 5'd0);
    check("t6_fifo_loaded", out_valid, 1);
    do_reset();
    out_pop = 1'b1;
    send(1'b1, 1'b1, 5'd0);
    check("t6_pkt_count",   pkt_count,  1);
    check("t6_last_len",    last_len,   32);
    check("t6_no_err_eop",  err_no_eop, 0);

    // Boundaries: one-byte beat and length saturation.
    send(1'b1, 1'b1, 5'd31);
    check("t7_one_byte",    last_len,  1);
    send(1'b1, 1'b0, 5'd0);
    repeat (2047) send(1'b0, 1'b0, 5'd0);
    send(1'b0, 1'b1, 5'd0);
    check("t7_saturated",   last_len,  16'hFFFF);
    check("t7_pkt_count",   pkt_count, 3);

    idle(3);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
